// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b one bit per clock, LSB first.
// Returns {borrow, difference} through valid/ready handshakes.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   d,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]   d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;

  logic             ai, bi, diff, br_n, last;
  logic [WIDTH-1:0] res_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    d         = d_q;
  end

  // One full-subtractor cell on the current LSBs.
  always_comb begin
    ai     = a_q[0];
    bi     = b_q[0];
    diff   = ai ^ bi ^ br_q;
    br_n   = (~ai & bi) | (~(ai ^ bi) & br_q);
    last   = (cnt_q == LAST);
    res_sh = {diff, res_q[WIDTH-1:1]};
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    br_d  = br_q;
    unique case (1'b1)
      (state_q == IDLE) && in_valid: begin
        a_d   = a;
        b_d   = b;
        res_d = '0;
        cnt_d = '0;
        br_d  = 1'b0;
      end
      (state_q == BUSY): begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_sh;
        cnt_d = cnt_q + CW'(1);
        br_d  = br_n;
        if (last) d_d = {br_n, res_sh};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      br_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
      br_q  <= br_d;
    end
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor: accepts two WIDTH-bit unsigned operands through a valid/ready handshake and computes a − b one bit per clock, LSB first. It returns a (WIDTH+1)-bit result of borrow plus difference. It is the inverse companion of the combinational FourBitAdder in the lab2 arithmetic set. Together the two allow round-trip checks: (a + b) − b = a.

## Interface
- WIDTH, 4, operand width in bits; legal range 2–16.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  minuend; sampled on acceptance
- b  input  WIDTH  subtrahend; sampled on acceptance
- in_valid  input  1  operands on a/b are valid
- in_ready  output  1  block can accept operands
- d  output  WIDTH+1  result: d[WIDTH] = borrow out, d[WIDTH-1:0] = (a − b) mod 2^WIDTH
- out_valid  output  1  d holds a completed result
- out_ready  input  1  consumer takes d

## Operation
- Reset is asynchronous, active-low. The following hold while rst_n = 0 and immediately after release:
  - state = IDLE
  - out_valid = 0
  - d = 0
  - internal shift registers, bit counter and borrow = 0
  - in_ready = 1, because in_ready is decoded combinationally as state == IDLE
- FSM has three states: IDLE, BUSY and DONE.
- IDLE: in_ready = 1. On a clk edge with in_valid = 1:
  - latch a and b into shift registers
  - clear borrow and the bit counter
  - move to BUSY
- BUSY: in_ready = 0. Each edge processes bit i = counter, LSB first:
  - diff_i = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - diff_i shifts into the result register from the MSB side; the operand registers shift right; the counter increments.
  - On the edge that processes bit WIDTH-1, load d = {br', result} and move to DONE.
- DONE: out_valid = 1, in_ready = 0.
  - d stays constant while in DONE.
  - On an edge with out_ready = 1, go to IDLE and clear out_valid. d keeps its last value.
- in_valid is ignored outside IDLE. There is no queuing, and a/b may change freely while the block is in BUSY or DONE.
- Arithmetic: d equals the 2^(WIDTH+1)-wrapped value of {1'b0,a} − {1'b0,b}. d[WIDTH] = 1 exactly when a < b.
- Reset asserted mid-operation (BUSY or DONE) aborts the operation immediately. No result is produced, and the block is back in IDLE with all outputs at their reset values.

## Timing
- Acceptance at edge E0 (IDLE, in_valid = 1).
- Bits 0 … WIDTH-1 are processed at edges E1 … E_WIDTH.
- out_valid rises after edge E_WIDTH. Latency from acceptance to out_valid is WIDTH cycles (4 cycles at the default width).
- Handshake completes at the first edge Ek with out_valid = 1 and out_ready = 1. After Ek, out_valid = 0 and in_ready = 1. The earliest next acceptance is the edge after Ek.
- There is no same-edge output-pop plus input-accept. Minimum issue interval is WIDTH + 2 cycles.
- out_ready held high before DONE: the result is consumed on the first DONE edge, so out_valid is high for exactly one cycle.
- in_ready and out_valid are never high in the same cycle.
- No combinational path from any input to out_valid or d. in_ready depends only on state.

## Test plan
- Basic subtraction (WIDTH = 4): accept a = 9, b = 3 with out_ready = 1. out_valid must rise exactly 4 cycles after acceptance with d = 5'b0_0110, and in_ready must return 1 one cycle after that.
- Borrow cases:
  - 3 − 9 → d = 5'b1_1010
  - 0 − 15 → d = 5'b1_0001
  - 15 − 15 → d = 5'b0_0000
  - 0 − 0 → d = 5'b0_0000
- Backpressure: complete 12 − 5 with out_ready = 0 for 10 cycles. out_valid must stay 1, d must hold 5'b0_0111, and in_ready must stay 0 throughout. Raising out_ready then gives out_valid = 0 after 1 edge.
- Ignored input: keep in_valid = 1 and toggle a/b every cycle during BUSY and DONE. The result must reflect only the first accepted pair, and no second operation may start until IDLE.
- Reset mid-operation: assert rst_n = 0 two cycles into BUSY. Outputs must immediately read out_valid = 0, d = 0 and in_ready = 1 without waiting for clk. A fresh 7 − 2 after release must give d = 5'b0_0101 with the standard latency.
- Exhaustive check: drive all 256 (a, b) pairs by incrementing a and b through 0–15, and compare each d against {1'b0,a} − {1'b0,b}. Also chain with FourBitAdder: feeding s[3:0] − b must return a whenever s[4] = 0.
